// File: rtl/prog_prescaler.sv
// Programmable clock-enable prescaler: divides clk by D = div_act+1 (1..2^DIV_W),
// producing a one-cycle tick per period and a registered near-50% clk_out level.
module prog_prescaler #(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick,
    output logic             clk_out,
    output logic [DIV_W-1:0] cnt,
    output logic [DIV_W-1:0] div_act,
    output logic             pend
);

    localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_DIV);

    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] shadow_nx;
    logic [DIV_W-1:0] div_act_nx;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W:0]   hi;
    logic             pend_nx;
    logic             tick_nx;
    logic             clk_out_nx;
    logic             wrap;
    logic             boundary;

    always_comb begin
        wrap      = en && !clr && (cnt == div_act);
        boundary  = clr || wrap;
        shadow_nx = div_load ? div_val : shadow;

        // A new divisor only lands where cnt restarts, so no period is ever cut short or stretched.
        div_act_nx = div_act;
        pend_nx    = pend | div_load;
        if (boundary) begin
            pend_nx = 1'b0;
            if (div_load)
                div_act_nx = div_val;
            else if (pend)
                div_act_nx = shadow;
        end

        hi = ({1'b0, div_act_nx} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

        cnt_nx     = cnt;
        tick_nx    = 1'b0;
        clk_out_nx = clk_out;
        if (clr) begin
            cnt_nx     = '0;
            clk_out_nx = 1'b0;
        end else if (en) begin
            cnt_nx     = wrap ? '0 : cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            tick_nx    = wrap;
            clk_out_nx = ({1'b0, cnt_nx} < hi);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            div_act <= RST_VAL;
            shadow  <= RST_VAL;
            pend    <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            tick    <= tick_nx;
            clk_out <= clk_out_nx;
            div_act <= div_act_nx;
            shadow  <= shadow_nx;
            pend    <= pend_nx;
        end
    end

endmodule
